// File: rtl/acc_sched_if.sv
// Control bundle between the PE array, the accumulator running-sum register
// and the output-row writeback for the acc_sched sequencer.
// slave modport: the sequencer side. master modport: the driving environment.
interface acc_sched_if #(
    parameter int CH_W  = 10,
    parameter int ROW_W = 6
);
    // job control
    logic             start_i;
    logic [CH_W-1:0]  cin_num_i;
    logic [ROW_W-1:0] row_num_i;
    logic             busy_o;
    logic             done_o;

    // beat admission from the PE array
    logic             in_valid_i;
    logic             in_ready_o;
    logic [CH_W-1:0]  ch_idx_o;

    // running-sum register strobes
    logic             acc_vld_o;
    logic             acc_first_o;
    logic             acc_last_o;

    // finished-row handoff to writeback
    logic             row_valid_o;
    logic             row_ready_i;
    logic [ROW_W-1:0] row_idx_o;

    // stall statistics
    logic [31:0]      perf_stall_o;

    modport slave (
        input  start_i, cin_num_i, row_num_i, in_valid_i, row_ready_i,
        output busy_o, done_o, in_ready_o, ch_idx_o,
               acc_vld_o, acc_first_o, acc_last_o,
               row_valid_o, row_idx_o, perf_stall_o
    );

    modport master (
        output start_i, cin_num_i, row_num_i, in_valid_i, row_ready_i,
        input  busy_o, done_o, in_ready_o, ch_idx_o,
               acc_vld_o, acc_first_o, acc_last_o,
               row_valid_o, row_idx_o, perf_stall_o
    );
endinterface

// File: rtl/acc_sched.sv
// acc_sched: control-only sequencer for the 3-stage row-partial accumulator.
// Admits one beat per input channel for each output row, tracks every beat
// through the fixed 3-cycle accumulator with a tag shift register, drives the
// running-sum first/last/valid strobes and hands finished rows to writeback.
// Optional feature: define ACC_SCHED_PERF_EN to enable the stall counter on
// perf_stall_o; otherwise perf_stall_o is tied to zero.
module acc_sched #(
    parameter int CH_W     = 10,
    parameter int ROW_W    = 6,
    parameter int PIPE_LAT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    acc_sched_if.slave   bus
);

    // The tag pipe below is hand-built for exactly three stages.
    generate
        if (PIPE_LAT != 3) begin : g_bad_pipe_lat
            $error("acc_sched supports PIPE_LAT == 3 only");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [CH_W-1:0]  cin_num;
    logic [ROW_W-1:0] row_num;
    logic [CH_W-1:0]  ch_idx;
    logic [ROW_W-1:0] row_idx;
    logic             in_ready_q;
    logic             done_q;
    logic             row_valid;
    logic             busy;

    logic             vld_p0, first_p0, last_p0;
    logic             vld_p1, first_p1, last_p1;
    logic             vld_p2, first_p2, last_p2;

    logic             counts_ok;
    logic             start_ok;
    logic             start_zero;
    logic             beat_hs;
    logic             beat_first;
    logic             beat_last;
    logic             row_hs;
    logic             row_last;

    assign counts_ok  = (bus.cin_num_i != '0) && (bus.row_num_i != '0);
    assign start_ok   = (state == IDLE) && bus.start_i && counts_ok;
    assign start_zero = (state == IDLE) && bus.start_i && !counts_ok;
    // in_ready_q is only ever set while in RUN, so it qualifies the handshake alone
    assign beat_hs    = in_ready_q && bus.in_valid_i;
    assign beat_first = (ch_idx == '0);
    assign beat_last  = (ch_idx == cin_num - CH_W'(1));
    assign row_hs     = (state == WB) && bus.row_ready_i;
    assign row_last   = (row_idx == row_num - ROW_W'(1));

    // Next-state selection and state-decoded outputs.
    always_comb begin
        next_state = state;
        row_valid  = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start_ok) next_state = RUN;
            end
            RUN: begin
                if (beat_hs && beat_last) next_state = DRAIN;
            end
            DRAIN: begin
                if (vld_p2 && last_p2) next_state = WB;
            end
            WB: begin
                row_valid = 1'b1;
                if (row_hs) next_state = row_last ? IDLE : RUN;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Registered ready and done strobes. The first RUN cycle of a job is the
    // count-latch cycle, so ready rises one cycle later; re-entry from WB is
    // ready immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            in_ready_q <= (next_state == RUN) && (state != IDLE);
            done_q     <= start_zero || (row_hs && row_last);
        end
    end

    // Job counts and channel/row indices.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cin_num <= '0;
            row_num <= '0;
            ch_idx  <= '0;
            row_idx <= '0;
        end else begin
            if (start_ok) begin
                cin_num <= bus.cin_num_i;
                row_num <= bus.row_num_i;
                ch_idx  <= '0;
                row_idx <= '0;
            end else begin
                if (beat_hs) ch_idx <= beat_last ? '0 : ch_idx + CH_W'(1);
                if (row_hs && !row_last) row_idx <= row_idx + ROW_W'(1);
            end
        end
    end

    // Tag pipe mirroring the accumulator: stage p0 -> p1 -> p2 (output).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0; first_p0 <= 1'b0; last_p0 <= 1'b0;
            vld_p1 <= 1'b0; first_p1 <= 1'b0; last_p1 <= 1'b0;
            vld_p2 <= 1'b0; first_p2 <= 1'b0; last_p2 <= 1'b0;
        end else begin
            // stage 1: tag of the beat accepted this cycle, or an empty slot
            vld_p0   <= beat_hs;
            first_p0 <= beat_hs && beat_first;
            last_p0  <= beat_hs && beat_last;
            // stage 2
            vld_p1   <= vld_p0;
            first_p1 <= first_p0;
            last_p1  <= last_p0;
            // stage 3: aligned with the accumulator output
            vld_p2   <= vld_p1;
            first_p2 <= first_p1;
            last_p2  <= last_p1;
        end
    end

`ifdef ACC_SCHED_PERF_EN
    logic [31:0] perf_cnt;
    logic        stall_cyc;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign stall_cyc = ((state == RUN) && !bus.in_valid_i) ||
                       ((state == WB)  && !bus.row_ready_i);

    // Stall counter: cleared by an accepted start, frozen outside RUN/WB stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         perf_cnt <= '0;
        else if (start_ok)  perf_cnt <= '0;
        else if (stall_cyc) perf_cnt <= sat_inc32(perf_cnt);
    end

    assign bus.perf_stall_o = perf_cnt;
`else
    assign bus.perf_stall_o = '0;
`endif

    assign bus.in_ready_o  = in_ready_q;
    assign bus.acc_vld_o   = vld_p2;
    assign bus.acc_first_o = first_p2;
    assign bus.acc_last_o  = last_p2;
    assign bus.row_valid_o = row_valid;
    assign bus.row_idx_o   = row_idx;
    assign bus.ch_idx_o    = ch_idx;
    assign bus.busy_o      = busy;
    assign bus.done_o      = done_q;

endmodule

// File: tb/tb_acc_sched.sv
// Testbench for acc_sched: directed scenarios plus randomized jobs, checked
// against a transaction-level scoreboard that predicts, from the job counts
// and observed handshakes, when beats are accepted, when their tags emerge,
// when rows are offered and when the job completes.
module tb_acc_sched;
    localparam int CH_W  = 10;
    localparam int ROW_W = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    acc_sched_if #(.CH_W(CH_W), .ROW_W(ROW_W)) bus ();

    acc_sched #(.CH_W(CH_W), .ROW_W(ROW_W), .PIPE_LAT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- reference model (scoreboard) ----------------
    typedef struct {
        int due;
        bit first;
        bit last;
    } tag_t;

    tag_t        tq[$];
    int          acc_start_at, wb_start_at, busy_start_at, busy_end_at, done_at;
    bit          acc_on, wb_on, busy_on;
    int          m_cin, m_row, beat, rowcnt;
    logic [31:0] m_perf;
    int          n_acc, n_first, n_last, n_done;

    task automatic mdl_clear();
        tq.delete();
        acc_on = 0; wb_on = 0; busy_on = 0;
        acc_start_at = -1; wb_start_at = -1; busy_start_at = -1;
        busy_end_at = -1; done_at = -1;
        m_cin = 0; m_row = 0; beat = 0; rowcnt = 0;
        m_perf = 32'd0;
    endtask

    always @(negedge clk) begin
        tag_t tmp;
        bit   ev, ef, el, hs, stall;
        if (!rst_n) begin
            mdl_clear();
        end else begin
            if (cyc == acc_start_at)  acc_on  = 1;
            if (cyc == wb_start_at)   wb_on   = 1;
            if (cyc == busy_start_at) busy_on = 1;
            if (cyc == busy_end_at)   busy_on = 0;

            ev = 0; ef = 0; el = 0;
            if (tq.size() > 0 && tq[0].due == cyc) begin
                tmp = tq.pop_front();
                ev = 1; ef = tmp.first; el = tmp.last;
            end

            check("acc_tags", {29'd0, bus.acc_vld_o, bus.acc_first_o, bus.acc_last_o},
                  {29'd0, ev, ef, el});
            check("in_ready",  32'(bus.in_ready_o),  32'(acc_on));
            check("row_valid", 32'(bus.row_valid_o), 32'(wb_on));
            check("busy",      32'(bus.busy_o),      32'(busy_on));
            check("done",      32'(bus.done_o),      32'(cyc == done_at));
            if (acc_on) check("ch_idx",  32'(bus.ch_idx_o),  32'(beat));
            if (wb_on)  check("row_idx", 32'(bus.row_idx_o), 32'(rowcnt));
`ifdef ACC_SCHED_PERF_EN
            check("perf_stall", bus.perf_stall_o, m_perf);
`else
            check("perf_stall", bus.perf_stall_o, 32'd0);
`endif

            if (bus.in_valid_i && bus.in_ready_o)                  n_acc++;
            if (bus.acc_vld_o && bus.acc_first_o)                  n_first++;
            if (bus.acc_vld_o && bus.acc_last_o)                   n_last++;
            if (bus.done_o)                                        n_done++;

            stall = ((acc_on || cyc == busy_start_at) && !bus.in_valid_i) ||
                    (wb_on && !bus.row_ready_i);
            hs = acc_on && bus.in_valid_i;

            if (hs) begin
                tmp.due = cyc + 3; tmp.first = (beat == 0); tmp.last = (beat == m_cin - 1);
                tq.push_back(tmp);
                if (beat == m_cin - 1) begin
                    beat = 0; acc_on = 0;
                end else begin
                    beat++;
                end
            end
            if (ev && el) wb_start_at = cyc + 1;
            if (wb_on && bus.row_ready_i) begin
                wb_on = 0;
                if (rowcnt == m_row - 1) begin
                    done_at = cyc + 1; busy_end_at = cyc + 1;
                end else begin
                    rowcnt++; acc_start_at = cyc + 1;
                end
            end

            if (!busy_on && bus.start_i && bus.cin_num_i != 0 && bus.row_num_i != 0) begin
                m_perf = 32'd0;
                m_cin = int'(bus.cin_num_i); m_row = int'(bus.row_num_i);
                beat = 0; rowcnt = 0;
                busy_start_at = cyc + 1; acc_start_at = cyc + 2;
            end else begin
                if (stall && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
                if (!busy_on && bus.start_i) done_at = cyc + 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int c, input int r);
        bus.cin_num_i = CH_W'(c);
        bus.row_num_i = ROW_W'(r);
        bus.start_i   = 1'b1;
        tick();
        bus.start_i   = 1'b0;
    endtask

    task automatic run_job(input int c, input int r, input bit rnd, input int budget);
        bit seen;
        seen = 0;
        start_job(c, r);
        for (int i = 0; i < budget && !seen; i++) begin
            if (rnd) begin
                bus.in_valid_i  = ($urandom_range(0, 3) != 0);
                bus.row_ready_i = ($urandom_range(0, 3) != 0);
                bus.start_i     = bus.busy_o && ($urandom_range(0, 7) == 0);
                bus.cin_num_i   = CH_W'($urandom_range(0, 9));
                bus.row_num_i   = ROW_W'($urandom_range(0, 4));
            end
            tick();
            if (bus.done_o) seen = 1;
        end
        bus.start_i = 1'b0;
        check("job_done", 32'(seen), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ROW_W-1:0] held_idx;
        mdl_clear();
        n_acc = 0; n_first = 0; n_last = 0; n_done = 0;

        // Reset with random inputs: all outputs low.
        for (int i = 0; i < 3; i++) begin
            bus.start_i     = 1'($urandom);
            bus.cin_num_i   = CH_W'($urandom);
            bus.row_num_i   = ROW_W'($urandom);
            bus.in_valid_i  = 1'($urandom);
            bus.row_ready_i = 1'($urandom);
            tick();
        end
        check("rst_in_ready",  32'(bus.in_ready_o),  32'd0);
        check("rst_acc",       {29'd0, bus.acc_vld_o, bus.acc_first_o, bus.acc_last_o}, 32'd0);
        check("rst_row_valid", 32'(bus.row_valid_o), 32'd0);
        check("rst_row_idx",   32'(bus.row_idx_o),   32'd0);
        check("rst_ch_idx",    32'(bus.ch_idx_o),    32'd0);
        check("rst_busy",      32'(bus.busy_o),      32'd0);
        check("rst_done",      32'(bus.done_o),      32'd0);
        check("rst_perf",      bus.perf_stall_o,     32'd0);
        bus.start_i = 0; bus.in_valid_i = 0; bus.row_ready_i = 0;
        bus.cin_num_i = '0; bus.row_num_i = '0;
        tick();
        rst_n = 1'b1;
        tick(); tick();

        // cin=1, row=1, valid/ready high: start in cycle 0.
        bus.in_valid_i = 1; bus.row_ready_i = 1;
        start_job(1, 1);                                    // now cycle 1
        check("t1_ready_c1", 32'(bus.in_ready_o), 32'd0);
        check("t1_busy_c1",  32'(bus.busy_o),     32'd1);
        tick();                                             // cycle 2
        check("t1_ready_c2", 32'(bus.in_ready_o), 32'd1);
        tick(); tick(); tick();                             // cycle 5
        check("t1_acc_c5", {29'd0, bus.acc_vld_o, bus.acc_first_o, bus.acc_last_o}, 32'd7);
        tick();                                             // cycle 6
        check("t1_rowv_c6", 32'(bus.row_valid_o), 32'd1);
        tick();                                             // cycle 7
        check("t1_done_c7", 32'(bus.done_o), 32'd1);
        check("t1_busy_c7", 32'(bus.busy_o), 32'd0);
        tick();

        // cin=4, row=2, continuous valid.
        n_acc = 0; n_first = 0; n_last = 0; n_done = 0;
        run_job(4, 2, 0, 60);
        tick(); tick();
        check("t2_accepts", 32'(n_acc),   32'd8);
        check("t2_firsts",  32'(n_first), 32'd2);
        check("t2_lasts",   32'(n_last),  32'd2);
        check("t2_dones",   32'(n_done),  32'd1);

        // Writeback backpressure for 5 cycles.
        bus.in_valid_i = 1; bus.row_ready_i = 0;
        start_job(2, 1);
        for (int i = 0; i < 20 && !bus.row_valid_o; i++) tick();
        check("bp_wb_reached", 32'(bus.row_valid_o), 32'd1);
        held_idx = bus.row_idx_o;
        for (int i = 0; i < 5; i++) begin
            check("bp_row_valid", 32'(bus.row_valid_o), 32'd1);
            check("bp_row_idx",   32'(bus.row_idx_o),   32'(held_idx));
            check("bp_in_ready",  32'(bus.in_ready_o),  32'd0);
            tick();
        end
`ifdef ACC_SCHED_PERF_EN
        check("bp_perf", bus.perf_stall_o, 32'd5);
`else
        check("bp_perf", bus.perf_stall_o, 32'd0);
`endif
        bus.row_ready_i = 1;
        tick();
        check("bp_done", 32'(bus.done_o), 32'd1);
        tick();

        // Zero channel count: immediate done, never busy.
        n_first = 0; n_last = 0;
        start_job(0, 3);
        check("zc_done", 32'(bus.done_o), 32'd1);
        check("zc_busy", 32'(bus.busy_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("zc_busy_after", 32'(bus.busy_o),    32'd0);
            check("zc_acc_after",  32'(bus.acc_vld_o), 32'd0);
        end
        start_job(5, 0);
        check("zr_done", 32'(bus.done_o), 32'd1);
        tick();

        // Reset in DRAIN with beats in flight.
        bus.in_valid_i = 1; bus.row_ready_i = 1;
        start_job(4, 1);
        for (int i = 0; i < 5; i++) tick();                 // first DRAIN cycle
        check("mr_draining", 32'(bus.busy_o && !bus.in_ready_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mr_busy_async", 32'(bus.busy_o),    32'd0);
        check("mr_acc_async",  32'(bus.acc_vld_o), 32'd0);
        tick();
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            check("mr_acc_after", 32'(bus.acc_vld_o), 32'd0);
            tick();
        end
        check("mr_no_done", 32'(n_done), 32'd0);
        run_job(3, 2, 0, 60);
        tick();

        // Randomized jobs with random valid/ready and ignored starts while busy.
        for (int j = 0; j < 10; j++) begin
            int c, r;
            c = (j == 9) ? 17 : int'($urandom_range(1, 6));
            r = int'($urandom_range(1, 3));
            bus.in_valid_i = 1'($urandom); bus.row_ready_i = 1'($urandom);
            run_job(c, r, 1, (c + 8) * r * 8 + 50);
            bus.in_valid_i = 0; bus.row_ready_i = 0;
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
        end

        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/acc_sched.md
# acc_sched

Sequencer for the 3-stage row-partial accumulator in the 3x3 conv datapath. For each output row it admits one beat of 3-row partial products per input channel. It tracks each admitted beat through the fixed 3-cycle accumulator pipeline with a tag shift register. It drives first/last/valid strobes to the running-sum register, then hands the finished row to the writeback side under a valid/ready handshake. It sits between the PE array (producer) and the output-row buffer (consumer); it carries no data, only control.

## Interface
- `CH_W`, 10, width of channel count/index
- `ROW_W`, 6, width of row count/index
- `PIPE_LAT`, 3, accumulator pipeline depth in cycles (fixed 3; other values unsupported)

- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `start_i` in 1: job start pulse; sampled only in IDLE
- `cin_num_i` in CH_W: input channels per row, latched at start
- `row_num_i` in ROW_W: output rows in job, latched at start
- `in_valid_i` in 1: PE array beat available
- `in_ready_o` out 1: beat accepted when `in_valid_i && in_ready_o`
- `acc_vld_o` out 1: accumulator stage-3 output holds a valid beat
- `acc_first_o` out 1: qualifies `acc_vld_o`; beat is channel 0, so the running sum loads instead of adding
- `acc_last_o` out 1: qualifies `acc_vld_o`; beat is the last channel
- `row_valid_o` out 1: finished row available to writeback
- `row_ready_i` in 1: writeback accepts row
- `row_idx_o` out ROW_W: index of row in progress / presented
- `ch_idx_o` out CH_W: channel index of next beat to accept
- `busy_o` out 1: state != IDLE
- `done_o` out 1: one-cycle job-complete pulse
- `perf_stall_o` out 32: stall counter (see Configuration)

## Operation
- Reset values: all outputs 0, state IDLE, counters 0, tag pipe cleared.
- States:
  - IDLE:
    - `start_i` with both counts nonzero: latch counts, clear indices, go to RUN.
    - `start_i` with either count 0: stay IDLE, pulse `done_o` next cycle.
  - RUN:
    - `in_ready_o` = 1.
    - On each handshake, push tag {vld=1, first=(ch_idx==0), last=(ch_idx==cin_num-1)} into the tag pipe.
    - On a non-last handshake, `ch_idx` increments.
    - On the last handshake, `ch_idx` returns to 0 and the state goes to DRAIN.
  - DRAIN:
    - `in_ready_o` = 0.
    - When the tag at stage 3 has last=1, go to WB next cycle.
  - WB:
    - `row_valid_o` = 1, held until `row_ready_i`.
    - On the handshake, if `row_idx == row_num-1`: go to IDLE and pulse `done_o` next cycle.
    - Otherwise `row_idx` increments and the state returns to RUN.
- Tag pipe:
  - 3-entry shift register, advances every cycle; never stalls.
  - `acc_vld_o`, `acc_first_o`, `acc_last_o` are the stage-3 tag bits.
  - Cycles without a handshake push an invalid tag (all zeros).
- `cin_num == 1`: the single beat carries first=last=1.
- `start_i` while busy is ignored; latched counts are unaffected.
- Index counters compare against latched `count-1` with no wrap beyond it; counts are unsigned.
- Reset mid-operation clears the state and tag pipe immediately. In-flight beats are dropped and no `done_o` is issued.

## Timing
- Beat handshake in cycle 0 → `acc_vld_o` with its tags high in cycle 3.
- Last-beat `acc_vld_o` in cycle 3 → `row_valid_o` high from cycle 4.
- `done_o` is high in the cycle after the final row handshake.
- `in_ready_o` is a registered state decode and does not depend on `in_valid_i`.
- Per-row minimum: C accept cycles + 4 cycles + writeback wait. With `row_ready_i` high, the next row's first accept is the cycle after the row handshake.
- With `in_valid_i` continuously high in RUN, accepts are back-to-back, one per cycle.

## Configuration
- Macro `ACC_SCHED_PERF_EN`.
- Defined:
  - `perf_stall_o` counts cycles in RUN with `in_valid_i`=0, plus cycles in WB with `row_ready_i`=0.
  - Cleared on an accepted start; saturates at 2^32-1; holds its value in IDLE.
- Undefined: `perf_stall_o` is tied to 0 and the counter logic is absent.

## Test plan
- Reset: assert `rst_n`=0 with random inputs → every output 0; `busy_o`=0.
- `cin`=1, `row`=1, valid/ready always high, start at cycle 0:
  - accept in cycle 2;
  - `acc_vld_o`/`first`/`last` = 1/1/1 in cycle 5;
  - `row_valid_o` high in cycle 6;
  - `done_o` in cycle 7.
- `cin`=4, `row`=2, continuous valid:
  - 4 consecutive accepts per row;
  - `acc_first_o` only on beat 0 and `acc_last_o` only on beat 3 of each row;
  - `row_idx_o` goes 0 then 1;
  - exactly one `done_o`.
- Backpressure: `row_ready_i` low for 5 cycles in WB → `row_valid_o` and `row_idx_o` held stable, `in_ready_o`=0; with PERF_EN, `perf_stall_o`=5.
- Zero count: start with `cin_num_i`=0, `row_num_i`=3 → `done_o` the next cycle, `busy_o` never 1, no `acc_vld_o`.
- Reset mid-job: drop `rst_n` in DRAIN with 2 beats in flight → `acc_vld_o` stays 0 afterwards; a new start runs normally.
